// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control unit.
package ctrl_pkg;

   // Controller sequencing states.
   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StMemRd,
      StMemWr,
      StWb
   } state_e;

   // Instruction classes recognised by the decoder.
   typedef enum logic [2:0] {
      ClsR,
      ClsI,
      ClsLd,
      ClsSt,
      ClsIll
   } instr_class_e;

   // Major opcodes.
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;

   // Native width of the ALU operation codes below.
   localparam int unsigned ALU_OP_W = 4;

   // ALU operation codes.
   localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0000;
   localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0001;
   localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0010;
   localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0011;
   localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0100;
   localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0101;
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0110;
   localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b0111;
   localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b1000;
   localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b1001;

   // Width of the memory wait counter; holds any timeout in 1..255.
   localparam int unsigned WAIT_W = 8;

   // funct3 -> ALU code; alt selects SUB/SRA on the two dual-use encodings.
   function automatic logic [ALU_OP_W-1:0] alu_op_map(input logic [2:0] f3, input logic alt);
      logic [ALU_OP_W-1:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational instruction decoder: class and ALU operation from opcode/funct fields.
module alu_decoder
   import ctrl_pkg::*;
(
   input  logic [6:0]          i_opcode,
   input  logic [2:0]          i_funct3,
   input  logic [6:0]          i_funct7,
   output logic [ALU_OP_W-1:0] o_alu_cc,
   output instr_class_e        o_class
);

   logic w_alt;
   logic w_f7_ok;
   logic w_f7_zero;

   assign w_alt     = i_funct7[5];
   assign w_f7_zero = (i_funct7 == 7'b0000000);
   assign w_f7_ok   = w_f7_zero || (i_funct7 == 7'b0100000);

   // Classify the instruction and pick its ALU operation; anything unmatched is illegal.
   always_comb begin
      o_alu_cc = ALU_ADD;
      o_class  = ClsIll;
      case (i_opcode)
         OP_R: begin
            // alt only legal on the ADD/SUB and SRL/SRA encodings
            if (w_f7_ok && (!w_alt || i_funct3 == 3'b000 || i_funct3 == 3'b101)) begin
               o_class  = ClsR;
               o_alu_cc = alu_op_map(i_funct3, w_alt);
            end
         end
         OP_I: begin
            if (i_funct3 == 3'b001) begin
               if (w_f7_zero) begin
                  o_class  = ClsI;
                  o_alu_cc = ALU_SLL;
               end
            end else if (i_funct3 == 3'b101) begin
               if (w_f7_ok) begin
                  o_class  = ClsI;
                  o_alu_cc = alu_op_map(i_funct3, w_alt);
               end
            end else begin
               // funct7 is immediate data here, so ADDI never becomes SUB
               o_class  = ClsI;
               o_alu_cc = alu_op_map(i_funct3, 1'b0);
            end
         end
         OP_LD: begin
            if (i_funct3 == 3'b010) begin
               o_class  = ClsLd;
               o_alu_cc = ALU_ADD;
            end
         end
         OP_ST: begin
            if (i_funct3 == 3'b010) begin
               o_class  = ClsSt;
               o_alu_cc = ALU_ADD;
            end
         end
         default: begin
            o_class  = ClsIll;
            o_alu_cc = ALU_ADD;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback for
// R-type, I-type ALU, LW and SW, with a timed mem_ready handshake.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned ALU_CC_W    = 4,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [6:0]          i_opcode,
   input  logic [2:0]          i_funct3,
   input  logic [6:0]          i_funct7,
   input  logic                i_mem_ready,
   output logic                o_pc_write,
   output logic                o_ir_write,
   output logic                o_reg_write,
   output logic                o_mem2reg,
   output logic                o_alu_src,
   output logic                o_mem_write,
   output logic                o_mem_read,
   output logic [ALU_CC_W-1:0] o_alu_cc,
   output logic                o_illegal_instr,
   output logic                o_mem_err,
   output logic [CNT_W-1:0]    o_retired_cnt
);

   state_e              r_state;
   state_e              w_state_nxt;
   logic [6:0]          r_opcode;
   logic [2:0]          r_funct3;
   logic [6:0]          r_funct7;
   instr_class_e        r_class;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic [CNT_W-1:0]    r_retired_cnt;

   logic [6:0]          w_dec_opcode;
   logic [2:0]          w_dec_funct3;
   logic [6:0]          w_dec_funct7;
   logic [ALU_OP_W-1:0] w_dec_alu_cc;
   instr_class_e        w_dec_class;
   logic [ALU_OP_W-1:0] w_alu_cc;
   logic                w_in_mem;
   logic                w_timeout;
   logic                w_retire;

   // Live fields are decoded only in DECODE; afterwards the latched copy drives the
   // decoder, so opcode can never reach the outputs outside DECODE.
   assign w_dec_opcode = (r_state == StDecode) ? i_opcode : r_opcode;
   assign w_dec_funct3 = (r_state == StDecode) ? i_funct3 : r_funct3;
   assign w_dec_funct7 = (r_state == StDecode) ? i_funct7 : r_funct7;

   alu_decoder u_alu_decoder (
      .i_opcode (w_dec_opcode),
      .i_funct3 (w_dec_funct3),
      .i_funct7 (w_dec_funct7),
      .o_alu_cc (w_dec_alu_cc),
      .o_class  (w_dec_class)
   );

   assign w_in_mem = (r_state == StMemRd) || (r_state == StMemWr);
   // Final permitted wait cycle with no ready; a late ready still counts as success.
   assign w_timeout = w_in_mem && !i_mem_ready && (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

   assign o_alu_cc      = ALU_CC_W'(w_alu_cc);
   assign o_retired_cnt = r_retired_cnt;

   // Next-state and Moore outputs from state, latched decode and wait counter.
   always_comb begin
      w_state_nxt     = r_state;
      o_pc_write      = 1'b0;
      o_ir_write      = 1'b0;
      o_reg_write     = 1'b0;
      o_mem2reg       = 1'b0;
      o_alu_src       = 1'b0;
      o_mem_write     = 1'b0;
      o_mem_read      = 1'b0;
      o_illegal_instr = 1'b0;
      o_mem_err       = 1'b0;
      w_alu_cc        = '0;
      w_retire        = 1'b0;
      case (r_state)
         StIdle: begin
            w_state_nxt = StFetch;
         end
         StFetch: begin
            o_ir_write  = 1'b1;
            o_pc_write  = 1'b1;
            w_state_nxt = StDecode;
         end
         StDecode: begin
            if (w_dec_class == ClsIll) begin
               o_illegal_instr = 1'b1;
               w_state_nxt     = StFetch;
            end else begin
               w_state_nxt = StExec;
            end
         end
         StExec: begin
            w_alu_cc  = w_dec_alu_cc;
            o_alu_src = (r_class != ClsR);
            case (r_class)
               ClsR, ClsI: w_state_nxt = StWb;
               ClsLd:      w_state_nxt = StMemRd;
               ClsSt:      w_state_nxt = StMemWr;
               default:    w_state_nxt = StFetch;
            endcase
         end
         StMemRd: begin
            o_mem_read = 1'b1;
            o_alu_src  = 1'b1;
            w_alu_cc   = ALU_ADD;
            if (i_mem_ready) begin
               w_state_nxt = StWb;
            end else if (w_timeout) begin
               o_mem_err   = 1'b1;
               w_state_nxt = StFetch;
            end
         end
         StMemWr: begin
            o_mem_write = 1'b1;
            o_alu_src   = 1'b1;
            w_alu_cc    = ALU_ADD;
            if (i_mem_ready) begin
               w_retire    = 1'b1;
               w_state_nxt = StFetch;
            end else if (w_timeout) begin
               o_mem_err   = 1'b1;
               w_state_nxt = StFetch;
            end
         end
         StWb: begin
            o_reg_write = 1'b1;
            o_mem2reg   = (r_class == ClsLd);
            o_alu_src   = (r_class != ClsR);
            w_alu_cc    = w_dec_alu_cc;
            w_retire    = 1'b1;
            w_state_nxt = StFetch;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // State, decode latch, memory wait counter and retired-instruction counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= StIdle;
         r_opcode      <= '0;
         r_funct3      <= '0;
         r_funct7      <= '0;
         r_class       <= ClsR;
         r_wait_cnt    <= '0;
         r_retired_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == StDecode) begin
            r_opcode <= i_opcode;
            r_funct3 <= i_funct3;
            r_funct7 <= i_funct7;
            r_class  <= w_dec_class;
         end
         // Counts stalled memory cycles; zero in every other state, so it is clear on entry.
         if (w_in_mem && !i_mem_ready) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
         end else begin
            r_wait_cnt <= '0;
         end
         if (w_retire) begin
            r_retired_cnt <= r_retired_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;

   // Control vector: {pc_write, ir_write, reg_write, mem2reg, alu_src,
   //                  mem_write, mem_read, illegal_instr, mem_err}
   localparam logic [8:0] S_NONE     = 9'b0_0_0_0_0_0_0_0_0;
   localparam logic [8:0] S_FETCH    = 9'b1_1_0_0_0_0_0_0_0;
   localparam logic [8:0] S_ILL      = 9'b0_0_0_0_0_0_0_1_0;
   localparam logic [8:0] S_EXEC_IMM = 9'b0_0_0_0_1_0_0_0_0;
   localparam logic [8:0] S_MEMRD    = 9'b0_0_0_0_1_0_1_0_0;
   localparam logic [8:0] S_MEMWR    = 9'b0_0_0_0_1_1_0_0_0;
   localparam logic [8:0] S_MEMWR_TO = 9'b0_0_0_0_1_1_0_0_1;
   localparam logic [8:0] S_WB_R     = 9'b0_0_1_0_0_0_0_0_0;
   localparam logic [8:0] S_WB_IMM   = 9'b0_0_1_0_1_0_0_0_0;
   localparam logic [8:0] S_WB_LD    = 9'b0_0_1_1_1_0_0_0_0;

   logic        clk;
   logic        rst_n;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        mem_ready;
   logic        pc_write, ir_write, reg_write, mem2reg, alu_src;
   logic        mem_write, mem_read, illegal_instr, mem_err;
   logic [3:0]  alu_cc;
   logic [31:0] retired_cnt;
   logic [8:0]  sig;

   int n_checks;
   int n_errors;
   int exp_ret;

   assign sig = {pc_write, ir_write, reg_write, mem2reg, alu_src,
                 mem_write, mem_read, illegal_instr, mem_err};

   multicycle_ctrl #(
      .ALU_CC_W    (4),
      .MEM_TIMEOUT (15),
      .CNT_W       (32)
   ) u_dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_opcode        (opcode),
      .i_funct3        (funct3),
      .i_funct7        (funct7),
      .i_mem_ready     (mem_ready),
      .o_pc_write      (pc_write),
      .o_ir_write      (ir_write),
      .o_reg_write     (reg_write),
      .o_mem2reg       (mem2reg),
      .o_alu_src       (alu_src),
      .o_mem_write     (mem_write),
      .o_mem_read      (mem_read),
      .o_alu_cc        (alu_cc),
      .o_illegal_instr (illegal_instr),
      .o_mem_err       (mem_err),
      .o_retired_cnt   (retired_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_sig(input string tag, input logic [8:0] exp);
      check({tag, " ctrl"}, 32'(sig), 32'(exp));
   endtask

   task automatic chk_cc(input string tag, input logic [3:0] exp);
      check({tag, " alu_cc"}, 32'(alu_cc), 32'(exp));
   endtask

   // Advance to the next negedge, then settle.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // FETCH cycle (also checks the retired count), present the instruction, then DECODE.
   task automatic fetch_decode(input string tag, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic ill);
      tick();
      chk_sig({tag, " fetch"}, S_FETCH);
      check({tag, " retired"}, retired_cnt, 32'(exp_ret));
      opcode = op;
      funct3 = f3;
      funct7 = f7;
      tick();
      chk_sig({tag, " decode"}, ill ? S_ILL : S_NONE);
   endtask

   // EXEC then WB for a register-writing ALU instruction; opcode is scrambled to prove latching.
   task automatic exec_wb(input string tag, input logic imm, input logic [3:0] cc);
      tick();
      opcode = 7'b1111111;
      funct3 = 3'b111;
      funct7 = 7'b1111111;
      #1;
      chk_sig({tag, " exec"}, imm ? S_EXEC_IMM : S_NONE);
      chk_cc({tag, " exec"}, cc);
      tick();
      chk_sig({tag, " wb"}, imm ? S_WB_IMM : S_WB_R);
      chk_cc({tag, " wb"}, cc);
      exp_ret++;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      exp_ret   = 0;
      rst_n     = 1'b0;
      opcode    = '0;
      funct3    = '0;
      funct7    = '0;
      mem_ready = 1'b0;

      // Reset held for 3 cycles, then IDLE with everything low.
      repeat (3) tick();
      chk_sig("in reset", S_NONE);
      check("in reset retired", retired_cnt, 32'd0);
      rst_n = 1'b1;
      #1;
      chk_sig("idle", S_NONE);
      chk_cc("idle", 4'b0000);

      // R-type SUB.
      fetch_decode("sub", 7'b0110011, 3'b000, 7'b0100000, 1'b0);
      exec_wb("sub", 1'b0, 4'b0110);

      // ADDI with funct7 bit5 set stays ADD; mem_ready outside memory states is ignored.
      fetch_decode("addi", 7'b0010011, 3'b000, 7'b0100000, 1'b0);
      mem_ready = 1'b1;
      exec_wb("addi", 1'b1, 4'b0010);

      // SRAI.
      fetch_decode("srai", 7'b0010011, 3'b101, 7'b0100000, 1'b0);
      mem_ready = 1'b0;
      exec_wb("srai", 1'b1, 4'b1000);

      // R-type SLTU.
      fetch_decode("sltu", 7'b0110011, 3'b011, 7'b0000000, 1'b0);
      exec_wb("sltu", 1'b0, 4'b1001);

      // LW with mem_ready on the third MEM_RD cycle.
      fetch_decode("lw", 7'b0000011, 3'b010, 7'b0000000, 1'b0);
      tick();
      chk_sig("lw exec", S_EXEC_IMM);
      chk_cc("lw exec", 4'b0010);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) mem_ready = 1'b1;
         #1;
         chk_sig($sformatf("lw mem%0d", i), S_MEMRD);
         chk_cc($sformatf("lw mem%0d", i), 4'b0010);
      end
      tick();
      mem_ready = 1'b0;
      chk_sig("lw wb", S_WB_LD);
      exp_ret++;

      // SW never acknowledged: 15 write cycles, mem_err on the last, no retire.
      fetch_decode("sw_to", 7'b0100011, 3'b010, 7'b0000000, 1'b0);
      tick();
      chk_sig("sw_to exec", S_EXEC_IMM);
      for (int i = 0; i < 15; i++) begin
         tick();
         chk_sig($sformatf("sw_to mem%0d", i), (i == 14) ? S_MEMWR_TO : S_MEMWR);
      end

      // SW acknowledged on the timeout cycle counts as success.
      fetch_decode("sw_late", 7'b0100011, 3'b010, 7'b0000000, 1'b0);
      tick();
      chk_sig("sw_late exec", S_EXEC_IMM);
      for (int i = 0; i < 15; i++) begin
         tick();
         if (i == 14) mem_ready = 1'b1;
         #1;
         chk_sig($sformatf("sw_late mem%0d", i), S_MEMWR);
      end
      exp_ret++;

      // Illegal encodings: each pulses illegal_instr in DECODE and returns to FETCH.
      fetch_decode("ill_op", 7'b1111111, 3'b000, 7'b0000000, 1'b1);
      mem_ready = 1'b0;
      fetch_decode("ill_f7", 7'b0110011, 3'b000, 7'b0000001, 1'b1);
      fetch_decode("ill_alt", 7'b0110011, 3'b100, 7'b0100000, 1'b1);
      fetch_decode("ill_slli", 7'b0010011, 3'b001, 7'b0100000, 1'b1);
      fetch_decode("ill_ld", 7'b0000011, 3'b000, 7'b0000000, 1'b1);

      // Reset during MEM_RD drops mem_read with no clock edge.
      fetch_decode("lw_rst", 7'b0000011, 3'b010, 7'b0000000, 1'b0);
      tick();
      chk_sig("lw_rst exec", S_EXEC_IMM);
      tick();
      chk_sig("lw_rst mem0", S_MEMRD);
      #1;
      rst_n = 1'b0;
      #1;
      chk_sig("async reset", S_NONE);
      check("async reset retired", retired_cnt, 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      chk_sig("post reset idle", S_NONE);
      tick();
      chk_sig("post reset fetch", S_FETCH);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control unit on the consumer side of the datapath control interface: takes opcode/funct3/funct7 and drives reg_write, mem2reg, alu_src, mem_write, mem_read and alu_cc.
- Adds pc_write/ir_write so the datapath can run one instruction over several cycles.
- Adds a mem_ready handshake so data memory may take a variable number of cycles.
- Supports R-type, I-type ALU, LW and SW.

Parameters:
- ALU_CC_W, 4, ALU control code width.
- MEM_TIMEOUT, 15, max cycles to wait for mem_ready before aborting (1..255).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  7  instruction[6:0] from the instruction register.
- funct3  in  3  instruction[14:12].
- funct7  in  7  instruction[31:25].
- mem_ready  in  1  data memory completion strobe.
- pc_write  out  1  PC register load enable (PC <= PC+4).
- ir_write  out  1  instruction register load enable.
- reg_write  out  1  register file write enable.
- mem2reg  out  1  writeback mux select (1 = memory data).
- alu_src  out  1  ALU B mux select (1 = immediate).
- mem_write  out  1  data memory write request.
- mem_read  out  1  data memory read request.
- alu_cc  out  ALU_CC_W  ALU operation code.
- illegal_instr  out  1  one-cycle pulse on undecodable instruction.
- mem_err  out  1  one-cycle pulse on memory timeout.
- retired_cnt  out  CNT_W  count of completed legal instructions.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB.
- Reset (reset=0, async): state=IDLE, all outputs 0, retired_cnt=0, wait counter=0, latched funct fields=0. IDLE -> FETCH unconditionally on the next edge.
- Outputs are Moore functions of state, latched decode and wait counter. No combinational path from opcode to outputs except in DECODE.
- FETCH: ir_write=1, pc_write=1 for exactly one cycle. -> DECODE.
- DECODE: latch opcode/funct3/funct7 and class (R, I, LD, ST, ILL).
  - ILL: illegal_instr=1 this cycle, -> FETCH.
  - Otherwise -> EXEC.
- EXEC: alu_cc per decode; alu_src=1 for I/LD/ST, 0 for R.
  - R/I -> WB; LD -> MEM_RD; ST -> MEM_WR.
- MEM_RD / MEM_WR: mem_read / mem_write held high; alu_src=1, alu_cc=ADD held stable.
  - Wait counter increments every cycle without mem_ready.
  - mem_ready=1: MEM_RD -> WB; MEM_WR -> FETCH and retired_cnt+1.
  - Counter reaches MEM_TIMEOUT without mem_ready: mem_err=1 for that cycle, request dropped, -> FETCH, retired_cnt unchanged.
  - mem_ready in the same cycle as the timeout: treated as success.
  - Counter clears on entry to MEM_RD/MEM_WR.
- WB: reg_write=1; mem2reg=1 for LD, 0 otherwise; alu_cc/alu_src held from EXEC. retired_cnt+1 -> FETCH.
- Latency: R/I = 4 cycles (FETCH..WB); LW = 5+N; SW = 4+N; N = mem_ready wait cycles.
- retired_cnt wraps modulo 2^CNT_W.
- mem_ready outside MEM states is ignored.
- reset asserted in any state: outputs drop to 0 immediately (async). Any in-flight memory request is abandoned.
- Decode, using funct7 bit 5 as "alt":
  - R (0110011):
    - f3 000: ADD, or SUB if alt.
    - 001 SLL; 010 SLT; 011 SLTU; 100 XOR.
    - 101: SRL, or SRA if alt.
    - 110 OR; 111 AND.
    - funct7 not 0000000/0100000 -> ILL; alt with f3 other than 000/101 -> ILL.
  - I (0010011): same map, except f3 000 is always ADD. f3 001/101 follow R funct7 legality; other f3 ignore funct7.
  - LD (0000011): f3=010 only, else ILL.
  - ST (0100011): f3=010 only, else ILL.
  - Any other opcode: ILL.

Decomposition:
- Package ctrl_pkg holds:
  - state enum.
  - instruction-class enum.
  - opcode constants: OP_R=0110011, OP_I=0010011, OP_LD=0000011, OP_ST=0100011.
  - ALU codes: AND=0000, OR=0001, ADD=0010, XOR=0011, SLL=0100, SRL=0101, SUB=0110, SLT=0111, SRA=1000, SLTU=1001.
- One combinational sub-module, alu_decoder (opcode, funct3, funct7 -> alu_cc, class), instantiated from DECODE latching.

Test Plan:
- Reset low 3 cycles, release -> all outputs 0 in IDLE; next cycle FETCH with ir_write=1, pc_write=1; retired_cnt=0.
- R SUB (opcode 0110011, f3 000, f7 0100000) -> EXEC alu_cc=0110, alu_src=0; WB reg_write=1, mem2reg=0; 4 cycles; retired_cnt=1.
- LW (f3 010), mem_ready high on 3rd MEM_RD cycle -> mem_read high exactly 3 cycles, alu_cc=0010; WB mem2reg=1, reg_write=1; retired_cnt+1.
- SW, mem_ready never -> mem_write high 15 cycles; mem_err pulses once; no reg_write; returns to FETCH; retired_cnt unchanged.
- Opcode 1111111, then R-type funct7 0000001 -> illegal_instr one-cycle pulse in DECODE each time; no reg/mem writes; back to FETCH.
- reset pulled low during MEM_RD -> mem_read falls same cycle without a clock edge; after release IDLE then FETCH.
